// File: rtl/slice_serial_adder_pkg.sv
// rtl/slice_serial_adder_pkg.sv - shared constants, state enum and counter sizing for the serial adder
package slice_serial_adder_pkg;

  // Slice width is tied to the 4-bit group-lookahead adder.
  localparam int SLICE_W       = 4;
  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the slice counter; never below one bit.
  function automatic int cnt_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/slice_serial_adder_ual.sv
// rtl/slice_serial_adder_ual.sv - 4-bit group-lookahead adder with group P/G and carry out
module slice_serial_adder_ual (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       p,
  output logic       g,
  output logic       c
);

  logic [3:0] pi;
  logic [3:0] gi;
  logic [3:0] cy;

  // Bit propagate/generate, lookahead carries, group terms.
  always_comb begin
    pi    = a ^ b;
    gi    = a & b;
    cy[0] = c_in;
    cy[1] = gi[0] | (pi[0] & c_in);
    cy[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & c_in);
    cy[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
          | (pi[2] & pi[1] & pi[0] & c_in);
    sum   = pi ^ cy;
    p     = &pi;
    g     = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
          | (pi[3] & pi[2] & pi[1] & gi[0]);
    c     = g | (p & c_in);
  end

endmodule

// File: rtl/slice_serial_adder.sv
// rtl/slice_serial_adder.sv - wide adder streaming one 4-bit slice per clock through a single group adder
module slice_serial_adder
  import slice_serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             prop_all,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = cnt_width(NSLICE);

  // Reject widths the slice datapath cannot handle.
  if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("slice_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  state_e                   state_q, state_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;
  logic [WIDTH-1:0]         a_sh_q, a_sh_d;
  logic [WIDTH-1:0]         b_sh_q, b_sh_d;
  // Only the upper WIDTH-4 result bits need storage; the last slice lands straight in sum.
  logic [WIDTH-SLICE_W-1:0] sum_sh_q, sum_sh_d;
  logic                     carry_q, carry_d;
  logic                     prop_acc_q, prop_acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     a_msb_q, a_msb_d;
  logic                     b_msb_q, b_msb_d;
  logic [WIDTH-1:0]         sum_q, sum_d;
  logic                     c_out_q, c_out_d;
  logic                     overflow_q, overflow_d;
  logic                     prop_all_q, prop_all_d;

  logic [SLICE_W-1:0]       slice_sum;
  logic                     slice_p;
  logic                     slice_c;
  logic                     ual_g_unused;
  logic [WIDTH-1:0]         final_sum;

  // The one group adder, fed with the low slice of each shift register.
  slice_serial_adder_ual u_ual (
    .a    (a_sh_q[SLICE_W-1:0]),
    .b    (b_sh_q[SLICE_W-1:0]),
    .c_in (carry_q),
    .sum  (slice_sum),
    .p    (slice_p),
    .g    (ual_g_unused),
    .c    (slice_c)
  );

  // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_sh_d    = sum_sh_q;
    carry_d     = carry_q;
    prop_acc_d  = prop_acc_q;
    cnt_d       = cnt_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    overflow_d  = overflow_q;
    prop_all_d  = prop_all_q;
    final_sum   = {slice_sum, sum_sh_q};

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          a_sh_d     = a;
          b_sh_d     = b;
          carry_d    = c_in;
          a_msb_d    = a[WIDTH-1];
          b_msb_d    = b[WIDTH-1];
          cnt_d      = '0;
          prop_acc_d = 1'b1;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        sum_sh_d   = final_sum[WIDTH-1:SLICE_W];
        a_sh_d     = a_sh_q >> SLICE_W;
        b_sh_d     = b_sh_q >> SLICE_W;
        carry_d    = slice_c;
        prop_acc_d = prop_acc_q & slice_p;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NSLICE - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          sum_d       = final_sum;
          c_out_d     = slice_c;
          prop_all_d  = prop_acc_q & slice_p;
          overflow_d  = (a_msb_q == b_msb_q) && (final_sum[WIDTH-1] != a_msb_q);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      carry_q     <= 1'b0;
      prop_acc_q  <= 1'b0;
      cnt_q       <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      overflow_q  <= 1'b0;
      prop_all_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      carry_q     <= carry_d;
      prop_acc_q  <= prop_acc_d;
      cnt_q       <= cnt_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      overflow_q  <= overflow_d;
      prop_all_q  <= prop_all_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign overflow  = overflow_q;
  assign prop_all  = prop_all_q;

endmodule

// File: tb/tb_slice_serial_adder.sv
// tb/tb_slice_serial_adder.sv - directed and random checks of the serial slice adder
module tb_slice_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        c_in = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] sum;
  logic        c_out;
  logic        overflow;
  logic        prop_all;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Free-running edge counter for accept spacing.
  always @(posedge clk) cyc <= cyc + 1;

  slice_serial_adder #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow),
    .prop_all  (prop_all),
    .busy      (busy)
  );

  // Present operands, wait for in_ready, and return one step after the accept edge.
  task automatic send(input logic [31:0] aa, input logic [31:0] bb, input logic ci,
                      output int waited);
    a = aa;
    b = bb;
    c_in = ci;
    in_valid = 1'b1;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count clock edges until out_valid is seen, capped at 50.
  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({in_ready, out_valid, c_out, overflow, prop_all, busy, sum} !== 38'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {in_ready, out_valid, c_out, overflow, prop_all, busy, sum});
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid, busy} !== 3'b000) begin
      bad++;
      $display("FAIL reset_held got=%b exp=000", {in_ready, out_valid, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_edge got=%b exp=0", in_ready);
    end
    @(posedge clk); #1;
    total++;
    if ({in_ready, busy} !== 2'b10) begin
      bad++;
      $display("FAIL ready_after_edge got=%b exp=10", {in_ready, busy});
    end
  endtask

  task automatic test_basic;
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic        vc [4];
    logic [31:0] es [4];
    logic [2:0]  ef [4];
    int w;
    int n;
    va[0] = 32'h0000_0001; vb[0] = 32'h0000_0002; vc[0] = 1'b0; es[0] = 32'h0000_0003; ef[0] = 3'b000;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0001; vc[1] = 1'b0; es[1] = 32'h0000_0000; ef[1] = 3'b100;
    va[2] = 32'h7FFF_FFFF; vb[2] = 32'h0000_0000; vc[2] = 1'b1; es[2] = 32'h8000_0000; ef[2] = 3'b010;
    va[3] = 32'hFFFF_0000; vb[3] = 32'h0000_FFFF; vc[3] = 1'b1; es[3] = 32'h0000_0000; ef[3] = 3'b101;
    for (int i = 0; i < 4; i++) begin
      send(va[i], vb[i], vc[i], w);
      wait_valid(n);
      total++;
      if (n !== 8 || w >= 50) begin
        bad++;
        $display("FAIL basic%0d_latency got=%0d exp=8 (ready wait %0d)", i, n, w);
      end
      total++;
      if (sum !== es[i]) begin
        bad++;
        $display("FAIL basic%0d_sum got=%h exp=%h", i, sum, es[i]);
      end
      total++;
      if ({c_out, overflow, prop_all} !== ef[i]) begin
        bad++;
        $display("FAIL basic%0d_flags got=%b exp=%b", i, {c_out, overflow, prop_all}, ef[i]);
      end
      total++;
      if ({busy, in_ready} !== 2'b10) begin
        bad++;
        $display("FAIL basic%0d_done_state got=%b exp=10", i, {busy, in_ready});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if ({out_valid, in_ready, busy, sum} !== {3'b010, es[i]}) begin
        bad++;
        $display("FAIL basic%0d_handshake got=%h exp=%h", i, {out_valid, in_ready, busy, sum}, {3'b010, es[i]});
      end
    end
  endtask

  task automatic test_stall;
    int w;
    int n;
    logic ok;
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, w);
    wait_valid(n);
    a = 32'hAAAA_0000;
    b = 32'h0000_5555;
    c_in = 1'b0;
    in_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if ({in_ready, out_valid, sum} !== {2'b01, 32'h0000_0100}) ok = 1'b0;
    end
    total++;
    if (ok !== 1'b1 || n !== 8) begin
      bad++;
      $display("FAIL stall_hold got=%h exp=%h latency=%0d", {in_ready, out_valid, sum}, {2'b01, 32'h0000_0100}, n);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL stall_release got=%b exp=01", {out_valid, in_ready});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if ({busy, in_ready} !== 2'b10) begin
      bad++;
      $display("FAIL stall_second_accept got=%b exp=10", {busy, in_ready});
    end
    wait_valid(n);
    total++;
    if (n !== 8 || sum !== 32'hAAAA_5555 || c_out !== 1'b0) begin
      bad++;
      $display("FAIL stall_second_sum got=%h/%0d exp=aaaa5555/8", sum, n);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int w;
    int n;
    logic seen;
    send(32'hDEAD_BEEF, 32'h0101_0101, 1'b1, w);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, c_out, overflow, prop_all, busy, sum} !== 38'd0) begin
      bad++;
      $display("FAIL abort_outputs got=%h exp=0", {in_ready, out_valid, c_out, overflow, prop_all, busy, sum});
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_valid got=%b exp=0", seen);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_ready got=%b exp=1", in_ready);
    end
    send(32'h1234_5678, 32'h1111_1111, 1'b0, w);
    wait_valid(n);
    total++;
    if (n !== 8 || {sum, c_out, overflow} !== {32'h2345_6789, 2'b00}) begin
      bad++;
      $display("FAIL abort_fresh_add got=%h/%0d exp=23456789/8", sum, n);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] aa;
    logic [31:0] bb;
    logic        ci;
    logic [32:0] ref_full;
    logic        ref_ov;
    int          prev;
    int          w;
    int          n;
    out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 1000; i++) begin
      aa = $urandom;
      bb = $urandom;
      ci = 1'($urandom_range(0, 1));
      ref_full = {1'b0, aa} + {1'b0, bb} + {32'd0, ci};
      ref_ov = (aa[31] == bb[31]) && (ref_full[31] != aa[31]);
      a = aa;
      b = bb;
      c_in = ci;
      in_valid = 1'b1;
      w = 0;
      while (in_ready !== 1'b1 && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      @(posedge clk); #1;
      if (i > 0) begin
        total++;
        if (cyc - prev !== 10) begin
          bad++;
          $display("FAIL b2b%0d_spacing got=%0d exp=10", i, cyc - prev);
        end
      end
      prev = cyc;
      wait_valid(n);
      total++;
      if (n !== 8 || {c_out, sum, overflow, prop_all} !== {ref_full, ref_ov, &(aa ^ bb)}) begin
        bad++;
        $display("FAIL b2b%0d_result got=%h/%0d exp=%h", i, {c_out, sum, overflow, prop_all}, n,
                 {ref_full, ref_ov, &(aa ^ bb)});
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_reset_mid_run;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
